// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone B3 classic arbiter with stall watchdog.
// The owner keeps the bus for its whole cyc period; the idle state costs one bubble cycle.
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);
  localparam bit WD_ON = (TIMEOUT != 0);

  state_t      state, state_nx;
  logic        last, last_nx;
  logic [15:0] cnt, cnt_nx;
  logic        own_cyc, own_stb;
  logic        wd_err;
  logic        resp;

  assign resp = s_ack_i | s_err_i;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    unique case (1'b1)
      state == OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
      end
      state == OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
      end
      default: ;
    endcase
  end

  // A slave response in the same cycle always beats the watchdog.
  assign wd_err = WD_ON && own_cyc && own_stb
                  && (cnt == TO) && !resp;

  assign s_cyc_o = own_cyc & ~wd_err;
  assign s_stb_o = own_stb & ~wd_err;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == OWN0) & s_ack_i;
  assign m1_ack_o = (state == OWN1) & s_ack_i;
  assign m0_err_o = (state == OWN0) & (s_err_i | wd_err);
  assign m1_err_o = (state == OWN1) & (s_err_i | wd_err);
  assign grant_o  = state;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    unique case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last))
          state_nx = OWN0;
        else if (m1_cyc_i)
          state_nx = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_nx = IDLE;
          last_nx  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_nx = IDLE;
          last_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt_nx = '0;
    if (WD_ON && !wd_err && own_cyc && own_stb && !resp)
      cnt_nx = cnt + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: a TIMEOUT=4 and a TIMEOUT=0 instance share stimulus,
// both checked every cycle against an ownership/stall model plus literal expectations.
module tb_wb_arbiter_2m;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];

  logic [31:0] s_dat_i;
  logic        s_ack_i = 1'b0;
  logic        s_err_i = 1'b0;

  logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
  logic [3:0]  a_s_sel;
  logic        a_m0_ack, a_m1_ack, a_m0_err, a_m1_err;
  logic        a_s_we, a_s_cyc, a_s_stb;
  logic [1:0]  a_grant;

  logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
  logic [3:0]  b_s_sel;
  logic        b_m0_ack, b_m1_ack, b_m0_err, b_m1_err;
  logic        b_s_we, b_s_cyc, b_s_stb;
  logic [1:0]  b_grant;

  wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(4)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(a_m0_dat), .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(a_m1_dat), .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel),
    .s_we_o(a_s_we), .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(a_grant)
  );

  wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(0)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(b_m0_dat), .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(b_m1_dat), .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel),
    .s_we_o(b_s_we), .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(b_grant)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slave: responds after slave_delay stalled cycles.
  assign s_dat_i = (a_s_adr == 32'h100) ? 32'hDEADBEEF
                                        : (a_s_adr ^ 32'hA5A5_0000);
  int   slave_delay = 0;
  logic slave_err = 1'b0;
  int   wait_c = 0;
  logic resp_nx = 1'b0;

  always @(negedge clk) begin
    if (a_s_cyc && a_s_stb && !s_ack_i && !s_err_i && !rst) begin
      if (wait_c >= slave_delay) begin
        resp_nx = 1'b1;
        wait_c  = 0;
      end else begin
        resp_nx = 1'b0;
        wait_c++;
      end
    end else begin
      resp_nx = 1'b0;
      wait_c  = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    s_ack_i = resp_nx && !slave_err;
    s_err_i = resp_nx && slave_err;
  end

  // Model: owner (0 idle, 1 m0, 2 m1), last served master, stall count.
  int own [2] = '{0, 0};
  int lst [2] = '{1, 1};
  int cnt [2] = '{0, 0};
  int to_v [2] = '{4, 0};

  function automatic logic wd(int k);
    int x;
    if (own[k] == 0 || to_v[k] == 0) return 1'b0;
    x = own[k] - 1;
    return m_cyc[x] && m_stb[x] && cnt[k] == to_v[k]
           && !s_ack_i && !s_err_i;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        own[k] = 0; lst[k] = 1; cnt[k] = 0;
      end else if (own[k] == 0) begin
        if (m_cyc[0] && m_cyc[1]) own[k] = (lst[k] == 0) ? 2 : 1;
        else if (m_cyc[0]) own[k] = 1;
        else if (m_cyc[1]) own[k] = 2;
        cnt[k] = 0;
      end else begin
        int x;
        x = own[k] - 1;
        if (!m_cyc[x]) begin
          lst[k] = x; own[k] = 0; cnt[k] = 0;
        end else if (wd(k)) cnt[k] = 0;
        else if (m_stb[x] && !s_ack_i && !s_err_i) cnt[k]++;
        else cnt[k] = 0;
      end
    end
  end

  task automatic cmp(int k, logic [31:0] adr, logic [31:0] dat,
                     logic [3:0] sel, logic we, logic cy, logic st,
                     logic a0, logic a1, logic e0, logic e1,
                     logic [31:0] d0, logic [31:0] d1, logic [1:0] g);
    logic [31:0] ea = 0, ed = 0;
    logic [3:0]  es = 0;
    logic ewe = 0, ecy = 0, est = 0;
    logic ea0 = 0, ea1 = 0, ee0 = 0, ee1 = 0;
    logic w;
    int x;
    w = wd(k);
    if (own[k] != 0) begin
      x = own[k] - 1;
      ea = m_adr[x]; ed = m_dat[x]; es = m_sel[x]; ewe = m_we[x];
      ecy = m_cyc[x] && !w;
      est = m_stb[x] && !w;
      if (x == 0) begin ea0 = s_ack_i; ee0 = s_err_i || w; end
      else begin ea1 = s_ack_i; ee1 = s_err_i || w; end
    end
    chk($sformatf("u%0d_s_adr", k), adr, ea);
    chk($sformatf("u%0d_s_dat", k), dat, ed);
    chk($sformatf("u%0d_s_sel", k), 32'(sel), 32'(es));
    chk($sformatf("u%0d_s_we", k), 32'(we), 32'(ewe));
    chk($sformatf("u%0d_s_cyc", k), 32'(cy), 32'(ecy));
    chk($sformatf("u%0d_s_stb", k), 32'(st), 32'(est));
    chk($sformatf("u%0d_m0_ack", k), 32'(a0), 32'(ea0));
    chk($sformatf("u%0d_m1_ack", k), 32'(a1), 32'(ea1));
    chk($sformatf("u%0d_m0_err", k), 32'(e0), 32'(ee0));
    chk($sformatf("u%0d_m1_err", k), 32'(e1), 32'(ee1));
    chk($sformatf("u%0d_m0_dat", k), d0, s_dat_i);
    chk($sformatf("u%0d_m1_dat", k), d1, s_dat_i);
    chk($sformatf("u%0d_grant", k), 32'(g),
        (own[k] == 1) ? 32'd1 : (own[k] == 2) ? 32'd2 : 32'd0);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp(0, a_s_adr, a_s_dat, a_s_sel, a_s_we, a_s_cyc, a_s_stb,
          a_m0_ack, a_m1_ack, a_m0_err, a_m1_err,
          a_m0_dat, a_m1_dat, a_grant);
      cmp(1, b_s_adr, b_s_dat, b_s_sel, b_s_we, b_s_cyc, b_s_stb,
          b_m0_ack, b_m1_ack, b_m0_err, b_m1_err,
          b_m0_dat, b_m1_dat, b_grant);
    end
  end

  // Event monitors for the literal expectations.
  int ack_c [2] = '{0, 0};
  int err_c [2] = '{0, 0};
  int b_err_c = 0;
  int bad_m1 = 0;
  int cyc_n = 0;
  logic [31:0] last_dat = 0, last_adr = 0;
  logic [1:0] glast = 2'b00;
  logic [1:0] glog [$];
  int gcyc [$];

  always @(negedge clk) begin
    if (a_m0_ack) begin
      ack_c[0]++;
      last_dat = a_m0_dat;
      last_adr = a_s_adr;
    end
    if (a_m1_ack) ack_c[1]++;
    if (a_m0_err) err_c[0]++;
    if (a_m1_err) err_c[1]++;
    if (b_m0_err || b_m1_err) b_err_c++;
    if (a_grant == 2'b01 && (a_m1_ack || a_m1_err)) bad_m1++;
    if (a_grant != glast) begin
      glog.push_back(a_grant);
      gcyc.push_back(cyc_n);
      glast = a_grant;
    end
    cyc_n++;
  end

  task automatic clear();
    ack_c = '{0, 0};
    err_c = '{0, 0};
    b_err_c = 0;
    bad_m1 = 0;
    glog.delete();
    gcyc.delete();
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic master(int m, logic [31:0] adr, int beats, logic we);
    int n = 0;
    int t = 0;
    m_adr[m] = adr;
    m_dat[m] = adr ^ 32'h1111_1111;
    m_sel[m] = 4'hF;
    m_we[m]  = we;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    while (n < beats && t < 200) begin
      @(negedge clk);
      if ((m == 0) ? (a_m0_ack || a_m0_err) : (a_m1_ack || a_m1_err))
        n++;
      t++;
      @(posedge clk);
      #1;
      if (n < beats) begin
        m_adr[m] = adr + 32'(4 * n);
        m_dat[m] = m_adr[m] ^ 32'h1111_1111;
      end
    end
    chk($sformatf("m%0d_beats", m), n, beats);
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
    m_we[m]  = 1'b0;
  endtask

  initial begin
    int q [$];
    int errk;
    logic es, bs;
    for (int i = 0; i < 2; i++) begin
      m_adr[i] = 0; m_dat[i] = 0; m_sel[i] = 0;
      m_we[i] = 0; m_cyc[i] = 0; m_stb[i] = 0;
    end

    // Reset
    rst = 1'b1;
    tick(1);
    chk_on = 1;
    tick(1);
    chk("reset_grant", 32'(a_grant), 0);
    chk("reset_scyc", 32'(a_s_cyc), 0);
    rst = 1'b0;
    tick(1);

    // Single m0 read
    clear();
    master(0, 32'h100, 1, 1'b0);
    tick(3);
    chk("rd_ack0", ack_c[0], 1);
    chk("rd_ack1", ack_c[1], 0);
    chk("rd_data", last_dat, 32'hDEADBEEF);
    chk("rd_adr", last_adr, 32'h100);
    chk("rd_glog_n", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("rd_glog0", 32'(glog[0]), 1);
      chk("rd_glog1", 32'(glog[1]), 0);
    end

    // Tie right after reset: m0 first, one idle bubble, then m1
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    clear();
    fork
      master(0, 32'h200, 1, 1'b0);
      master(1, 32'h300, 1, 1'b1);
    join
    tick(3);
    chk("tie_glog_n", glog.size(), 4);
    if (glog.size() >= 4) begin
      chk("tie_g0", 32'(glog[0]), 1);
      chk("tie_g1", 32'(glog[1]), 0);
      chk("tie_g2", 32'(glog[2]), 2);
      chk("tie_g3", 32'(glog[3]), 0);
      chk("tie_bubble", gcyc[2] - gcyc[1], 1);
    end

    // Continuous re-requests alternate
    clear();
    fork
      for (int i = 0; i < 4; i++) begin
        master(0, 32'h1000 + 32'(i * 16), 1, 1'b0);
        tick(1);
      end
      for (int i = 0; i < 4; i++) begin
        master(1, 32'h2000 + 32'(i * 16), 1, 1'b1);
        tick(1);
      end
    join
    tick(3);
    q.delete();
    foreach (glog[i]) if (glog[i] != 2'b00) q.push_back(int'(glog[i]));
    chk("rr_n", q.size(), 8);
    foreach (q[i]) chk($sformatf("rr_%0d", i), q[i], (i % 2 == 0) ? 1 : 2);

    // Locked 8-beat burst on m0 while m1 waits
    clear();
    fork
      master(0, 32'h400, 8, 1'b1);
      begin
        tick(2);
        master(1, 32'h800, 1, 1'b0);
      end
    join
    tick(3);
    chk("burst_ack0", ack_c[0], 8);
    chk("burst_ack1", ack_c[1], 1);
    chk("burst_m1_quiet", bad_m1, 0);
    q.delete();
    foreach (glog[i]) if (glog[i] != 2'b00) q.push_back(int'(glog[i]));
    chk("burst_n", q.size(), 2);
    if (q.size() >= 2) begin
      chk("burst_g0", q[0], 1);
      chk("burst_g1", q[1], 2);
    end

    // Watchdog: slave never answers
    clear();
    slave_delay = 1000;
    m_adr[0] = 32'h500;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    errk = -1;
    es = 1'b1;
    bs = 1'b0;
    for (int k = 1; k <= 20 && errk < 0; k++) begin
      @(negedge clk);
      if (a_m0_err) begin
        errk = k;
        es = a_s_stb;
        bs = b_s_stb;
      end
    end
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    tick(2);
    chk("wd_cycle", errk, 6);
    chk("wd_stb_forced", 32'(es), 0);
    chk("wd_off_stb", 32'(bs), 1);
    chk("wd_pulses", err_c[0], 1);
    chk("wd_off_err", b_err_c, 0);

    // Slave ack in the watchdog cycle wins
    clear();
    slave_delay = 3;
    master(0, 32'h600, 1, 1'b0);
    tick(2);
    chk("coll_ack", ack_c[0], 1);
    chk("coll_err", err_c[0], 0);

    // Slave error passed to owner
    clear();
    slave_delay = 0;
    slave_err = 1'b1;
    master(1, 32'h700, 1, 1'b1);
    slave_err = 1'b0;
    tick(2);
    chk("serr_err1", err_c[1], 1);
    chk("serr_ack1", ack_c[1], 0);

    // Reset in the middle of an m1 transfer
    clear();
    slave_delay = 1000;
    m_adr[1] = 32'h900;
    m_cyc[1] = 1'b1;
    m_stb[1] = 1'b1;
    tick(3);
    chk("mid_own1", 32'(a_grant), 2);
    m_adr[0] = 32'h940;
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_grant", 32'(a_grant), 0);
    chk("mid_scyc", 32'(a_s_cyc), 0);
    chk("mid_sstb", 32'(a_s_stb), 0);
    chk("mid_sadr", a_s_adr, 0);
    chk("mid_grant_b", 32'(b_grant), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    chk("mid_tie_m0", 32'(a_grant), 1);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick(4);
    slave_delay = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
